// File: rtl/ps2_cursor_tracker_if.sv
// ---------------------------------------------------------------------------
// ps2_cursor_tracker_if
//   Pixel-write request bus between the cursor tracker (master) and the
//   frame-buffer writer (slave). A write is accepted on a clock edge where
//   wr_req and wr_ack are both high.
//
//   wr_req    master -> slave  pixel write request, held until accepted
//   wr_x      master -> slave  write column (0..H_RES-1)
//   wr_y      master -> slave  write row (0..V_RES-1)
//   wr_color  master -> slave  palette index to write
//   wr_ack    slave  -> master write accepted when high with wr_req high
// ---------------------------------------------------------------------------
interface ps2_cursor_tracker_if;
  logic       wr_req;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [2:0] wr_color;
  logic       wr_ack;

  modport master (output wr_req, output wr_x, output wr_y, output wr_color,
                  input  wr_ack);
  modport slave  (input  wr_req, input  wr_x, input  wr_y, input  wr_color,
                  output wr_ack);
endinterface

// File: rtl/ps2_cursor_tracker.sv
// ---------------------------------------------------------------------------
// ps2_cursor_tracker
//   Consumes decoded PS/2 mouse packets (signed deltas + buttons), keeps an
//   absolute cursor clamped to the screen, cycles the paint colour on each
//   right-button press, pulses clear_req on each middle-button press, and
//   issues one pixel write per packet while the left button is held.
//   One packet can wait in a pending slot while the FSM is busy; packets
//   arriving while that slot is full are dropped and counted.
//
//   clk, reset   clock, asynchronous active-low reset
//   x_delta      signed X movement, right positive
//   y_delta      signed Y movement, up positive
//   left_btn / right_btn / mid_btn   button states in the packet
//   data_ready   one-cycle strobe qualifying deltas/buttons
//   cursor_x/y   current cursor position
//   pos_valid    one-cycle pulse when the cursor registers update
//   color_idx    current paint colour
//   clear_req    one-cycle pulse on a middle-button rising edge
//   wr           pixel-write bus (master side)
//   drop_cnt     saturating count of discarded packets
// ---------------------------------------------------------------------------
module ps2_cursor_tracker #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int SPEED_SHIFT = 0,
  parameter int N_COLORS    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8:0]                  x_delta,
  input  logic [8:0]                  y_delta,
  input  logic                        left_btn,
  input  logic                        right_btn,
  input  logic                        mid_btn,
  input  logic                        data_ready,
  output logic [9:0]                  cursor_x,
  output logic [9:0]                  cursor_y,
  output logic                        pos_valid,
  output logic [2:0]                  color_idx,
  output logic                        clear_req,
  ps2_cursor_tracker_if.master        wr,
  output logic [7:0]                  drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CLAMP, S_PAINT} state_t;

  typedef struct packed {
    logic [8:0] dx;
    logic [8:0] dy;
    logic       l;
    logic       r;
    logic       m;
  } pkt_t;

  localparam logic signed [11:0] X_MAX      = 12'(H_RES - 1);
  localparam logic signed [11:0] Y_MAX      = 12'(V_RES - 1);
  localparam logic [2:0]         COLOR_LAST = 3'(N_COLORS - 1);

  state_t            state;
  pkt_t              pend;
  logic              pend_valid;
  pkt_t              work;
  logic signed [11:0] sx, sy;
  logic              prev_r, prev_m;
  logic              wr_req_q;
  logic [9:0]        wr_x_q, wr_y_q;
  logic [2:0]        wr_color_q;

  logic              consume, capture;
  logic signed [11:0] dx_s, dy_s, sx_next, sy_next;
  logic [9:0]        clamp_x, clamp_y;
  logic [2:0]        color_next;
  logic              r_rise, m_rise;

  assign wr.wr_req   = wr_req_q;
  assign wr.wr_x     = wr_x_q;
  assign wr.wr_y     = wr_y_q;
  assign wr.wr_color = wr_color_q;

  // The slot may be refilled on the same edge the FSM empties it.
  assign consume = (state == S_IDLE) && pend_valid;
  assign capture = data_ready && (!pend_valid || consume);

  always_comb begin
    // NOTE: every output of this block is assigned before any condition, so
    // no path leaves a value held over and no latch can be inferred.
    dx_s       = $signed({{3{work.dx[8]}}, work.dx}) >>> SPEED_SHIFT;
    dy_s       = $signed({{3{work.dy[8]}}, work.dy}) >>> SPEED_SHIFT;
    // Screen Y grows downward while mouse Y is up-positive.
    sx_next    = $signed({2'b00, cursor_x}) + dx_s;
    sy_next    = $signed({2'b00, cursor_y}) - dy_s;
    clamp_x    = sx[9:0];
    clamp_y    = sy[9:0];
    if (sx[11])          clamp_x = '0;
    else if (sx > X_MAX) clamp_x = X_MAX[9:0];
    if (sy[11])          clamp_y = '0;
    else if (sy > Y_MAX) clamp_y = Y_MAX[9:0];
    r_rise     = work.r && !prev_r;
    m_rise     = work.m && !prev_m;
    color_next = (color_idx == COLOR_LAST) ? 3'd0 : color_idx + 3'd1;
  end

  // Pending slot and drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      // NOTE: the slot payload is qualified by pend_valid, so its reset only
      // keeps the datapath X-free; behaviour would not depend on it.
      pend       <= '0;
      drop_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register here sees the pre-edge values, independent of statement order.
      if (capture) begin
        pend       <= {x_delta, y_delta, left_btn, right_btn, mid_btn};
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      if (data_ready && !capture && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Packet-processing FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      work       <= '0;
      sx         <= '0;
      sy         <= '0;
      cursor_x   <= 10'(X_INIT);
      cursor_y   <= 10'(Y_INIT);
      color_idx  <= '0;
      prev_r     <= 1'b0;
      prev_m     <= 1'b0;
      pos_valid  <= 1'b0;
      clear_req  <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
    end else begin
      pos_valid <= 1'b0;
      clear_req <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pend_valid) begin
            work  <= pend;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          sx    <= sx_next;
          sy    <= sy_next;
          state <= S_CLAMP;
        end
        S_CLAMP: begin
          cursor_x  <= clamp_x;
          cursor_y  <= clamp_y;
          pos_valid <= 1'b1;
          clear_req <= m_rise;
          if (r_rise) color_idx <= color_next;
          prev_r    <= work.r;
          prev_m    <= work.m;
          if (work.l) begin
            // Write attributes are frozen here and held through the handshake.
            wr_x_q     <= clamp_x;
            wr_y_q     <= clamp_y;
            wr_color_q <= r_rise ? color_next : color_idx;
            state      <= S_PAINT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PAINT: begin
          // First PAINT cycle raises wr_req; wr_ack before that is ignored.
          if (!wr_req_q) begin
            wr_req_q <= 1'b1;
          end else if (wr.wr_ack) begin
            wr_req_q <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_cursor_tracker.md
Name: ps2_cursor_tracker

Overview:
- Downstream consumer of the PS/2 mouse packet controller.
- Takes per-packet signed X/Y deltas and button states, and accumulates them into an absolute cursor position clamped to the screen.
- Tracks the selected paint colour and issues pixel-write requests to the frame-buffer writer while the left button is held.
- Buffers one packet so a stalled write port does not lose motion.

Parameters:
- H_RES, 640, horizontal pixels; cursor_x range 0..H_RES-1
- V_RES, 480, vertical pixels; cursor_y range 0..V_RES-1
- X_INIT, 320, cursor_x after reset
- Y_INIT, 240, cursor_y after reset
- SPEED_SHIFT, 0, deltas arithmetically right-shifted by this amount before accumulation
- N_COLORS, 8, number of palette entries; colour index wraps modulo N_COLORS

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- x_delta  in  9  signed two's-complement X movement, right positive
- y_delta  in  9  signed two's-complement Y movement, up positive
- left_btn  in  1  left button state in packet
- right_btn  in  1  right button state in packet
- mid_btn  in  1  middle button state in packet
- data_ready  in  1  one-cycle strobe; deltas/buttons valid this cycle
- cursor_x  out  10  current cursor column
- cursor_y  out  10  current cursor row
- pos_valid  out  1  one-cycle pulse when the cursor registers update
- color_idx  out  3  current paint colour
- clear_req  out  1  one-cycle pulse on a middle-button rising edge
- wr_req  out  1  pixel write request
- wr_x  out  10  write column
- wr_y  out  10  write row
- wr_color  out  3  write colour
- wr_ack  in  1  write accepted when sampled high with wr_req high
- drop_cnt  out  8  saturating count of discarded packets

Behaviour:
- Reset (reset=0, asynchronous):
  - cursor_x=X_INIT, cursor_y=Y_INIT, color_idx=0, drop_cnt=0.
  - pos_valid, clear_req, wr_req = 0; wr_x/wr_y/wr_color = 0.
  - Pending slot empty; previous-button registers 0; FSM goes to IDLE.
  - A reset mid-write drops wr_req at once; the write is abandoned.
- Pending slot (one entry plus valid flag):
  - data_ready=1 with slot empty, or with the slot being consumed this cycle: capture all inputs and set valid.
  - data_ready=1 with slot full and not consumed: discard the packet; drop_cnt += 1, saturating at 255.
- FSM:
  - IDLE: if pending valid, copy the slot to working registers, clear valid (unless refilled the same cycle), go to ACCUM.
  - ACCUM: sign-extend deltas to 12 bits and arithmetic-shift by SPEED_SHIFT. Compute sx = cursor_x + dx and sy = cursor_y - dy; Y is inverted because the screen grows downward. Register the results and go to CLAMP.
  - CLAMP:
    - cursor_x = 0 if sx<0, H_RES-1 if sx>H_RES-1, else sx. cursor_y is clamped the same way against V_RES-1.
    - Pulse pos_valid.
    - Right-button rising edge (packet right=1, previous packet right=0): color_idx = (color_idx+1) mod N_COLORS; N_COLORS-1 wraps to 0.
    - Middle-button rising edge: pulse clear_req.
    - Update the previous-button registers.
    - If left=1, go to PAINT; else go to IDLE.
  - PAINT: drive wr_req=1 with wr_x/wr_y = the new cursor and wr_color = the updated color_idx, all held stable until wr_ack=1 is sampled. Deassert wr_req on the cycle after acceptance and go to IDLE. wr_ack while wr_req=0 is ignored.
- Latency with the FSM idle:
  - data_ready in cycle T → cursor/pos_valid/color/clear_req update in cycle T+3.
  - wr_req first asserted in cycle T+4.
- Back-to-back packets: consecutive packets are processed in arrival order. At most one packet waits; further arrivals while the slot is full are dropped.
- Zero delta: cursor unchanged, but pos_valid still pulses and a write is still issued if left=1.

Test Plan:
- Reset, then packet x=9'h005, y=9'h003, no buttons → cursor (325,237) at T+3, pos_valid one cycle, wr_req stays 0.
- Two packets x=9'h100 (-256) from reset → cursor_x 64, then 0 (clamped); two packets x=9'h0FF → 575, then 639 (clamped).
- Packet with left=1, wr_ack withheld 5 cycles → wr_req held with wr_x/wr_y/wr_color stable; drops to 0 the cycle after the ack; exactly one write.
- Eight right-button press/release packet pairs from color_idx=0 → increments to 7, then wraps to 0; a held right button across packets does not re-increment.
- Three packets with left=1 back-to-back, ack withheld → first in PAINT, second pending, third dropped, drop_cnt=1; after acks, two writes in order.
- reset=0 asserted during PAINT → wr_req=0 immediately, cursor (320,240), color_idx 0, drop_cnt 0.
